// File: rtl/decode_window_sequencer.sv
// decode_window_sequencer
//   Byte queue between instruction fetch and decode. Fetch pushes 4-byte
//   beats into a circular buffer of DEPTH bytes. Decode sees the oldest
//   8 queued bytes as a window and retires 0..8 bytes per cycle.
//
// Ports
//   i_clk                 clock, rising edge
//   i_rst_n               asynchronous active-low reset
//   i_flush               drop all queued bytes (redirect); blocks fetch
//   i_fetch_valid/data    4-byte fetch beat, oldest byte in [7:0]
//   o_fetch_ready         beat accepted this cycle
//   o_window[0:7]         decode window, [0] is the oldest byte
//   o_window_valid_bytes  min(count, 8)
//   i_consume_valid/bytes retire n bytes from the window head
//   o_consume_error       previous cycle asked for more bytes than valid
//   o_stall_count         cycles with an empty queue (saturating); present
//                         only when DECODE_STALL_COUNTER_EN is defined
module decode_window_sequencer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_data,
  output logic        o_fetch_ready,
  output logic [7:0]  o_window [0:7],
  output logic [3:0]  o_window_valid_bytes,
  input  logic        i_consume_valid,
  input  logic [3:0]  i_consume_bytes,
  output logic        o_consume_error
`ifdef DECODE_STALL_COUNTER_EN
  ,
  output logic [15:0] o_stall_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 4);

  logic [7:0]    mem [0:DEPTH-1];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          fetch_fire;
  logic          consume_legal;

  // Only the registered count gates ready; a same-cycle consume is not credited.
  assign o_fetch_ready        = !i_flush && (count <= READY_MAX);
  assign fetch_fire           = i_fetch_valid && o_fetch_ready;
  assign o_window_valid_bytes = (count >= CW'(8)) ? 4'd8 : count[3:0];
  // valid_bytes never exceeds 8, so this also rejects requests above 8.
  assign consume_legal        = i_consume_valid && (i_consume_bytes <= o_window_valid_bytes);

  always_comb begin
    for (int unsigned k = 0; k < 8; k++) begin
      o_window[k] = '0;
      if (CW'(k) < count) begin
        o_window[k] = mem[rd_ptr + AW'(k)];
      end
    end
  end

  // Storage is not reset; bytes beyond count are masked in the window.
  always_ff @(posedge i_clk) begin
    if (fetch_fire) begin
      for (int unsigned b = 0; b < 4; b++) begin
        mem[wr_ptr + AW'(b)] <= i_fetch_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      o_consume_error <= 1'b0;
    end else if (i_flush) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      o_consume_error <= 1'b0;
    end else begin
      o_consume_error <= i_consume_valid && !consume_legal;
      if (consume_legal) begin
        rd_ptr <= rd_ptr + AW'(i_consume_bytes);
      end
      if (fetch_fire) begin
        wr_ptr <= wr_ptr + AW'(4);
      end
      count <= count
             + (fetch_fire    ? CW'(4)               : '0)
             - (consume_legal ? CW'(i_consume_bytes) : '0);
    end
  end

`ifdef DECODE_STALL_COUNTER_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_count <= '0;
    end else if ((count == '0) && !i_flush && (o_stall_count != '1)) begin
      o_stall_count <= o_stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/decode_window_sequencer.md
DECODE_WINDOW_SEQUENCER -- requirements
Module: decode_window_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: byte-queue capacity, a power of two and at least 16.
REQ-002 SHALL have port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port i_flush, input, 1: discard all queued bytes, for branch or exception redirect.
REQ-005 SHALL have port i_fetch_valid, input, 1: a fetch beat is offered.
REQ-006 SHALL have port i_fetch_data, input, 32: fetch beat, oldest byte in [7:0] and newest in [31:24].
REQ-007 SHALL have port o_fetch_ready, output, 1: the queue accepts the offered beat this cycle.
REQ-008 SHALL have port o_window, output, 8 x 8 (array [0:7]): decode window, with o_window[0] the oldest queued byte.
REQ-009 SHALL have port o_window_valid_bytes, output, 4: number of valid window bytes, 0..8.
REQ-010 SHALL have port i_consume_valid, input, 1: decode retires bytes this cycle.
REQ-011 SHALL have port i_consume_bytes, input, 4: bytes retired, 0..8 (decode total: prefix, opcode, modrm/sib, displacement and immediate).
REQ-012 SHALL have port o_consume_error, output, 1: the previous cycle requested more bytes than were valid.

Function
REQ-013 SHALL hold bytes in a circular buffer of DEPTH bytes.
REQ-014 SHALL keep three registered state values: read pointer, write pointer and count, where count ranges 0..DEPTH.
REQ-015 SHALL drive o_fetch_ready = !i_flush && (count <= DEPTH-4), with count taken as the registered value; a same-cycle consume is not credited.
REQ-016 SHALL, on a fetch handshake (valid && ready), write 4 bytes at the write pointer, advance the write pointer by 4 modulo DEPTH, and add 4 to count.
REQ-017 SHALL drive each o_window[k] combinationally as buf[(rd_ptr+k) mod DEPTH] when k < count, and as 8'h00 otherwise.
REQ-018 SHALL drive o_window_valid_bytes = min(count, 8).
REQ-019 SHALL present bytes accepted in cycle N in the window from cycle N+1, giving one cycle of fill latency.
REQ-020 SHALL, for a legal consume (i_consume_valid && i_consume_bytes <= o_window_valid_bytes), advance the read pointer by n modulo DEPTH and subtract n from count.
REQ-021 SHALL treat a consume of 0 bytes as legal and as a no-op.
REQ-022 SHALL, for an illegal consume (n > o_window_valid_bytes, or n > 8), leave the pointers and count unchanged and assert o_consume_error for exactly the next cycle.
REQ-023 SHALL, on a simultaneous fetch and legal consume, set count_next = count + 4 - n; the result never exceeds DEPTH.
REQ-024 SHALL give i_flush priority over all other events: pointers and count go to 0 next cycle, and any same-cycle consume is ignored.
REQ-025 SHALL NOT accept a fetch beat while i_flush is high (o_fetch_ready is low).
REQ-026 SHALL NOT assert o_consume_error as a result of a consume ignored during a flush.
REQ-027 SHALL wrap pointers modulo DEPTH with no data corruption across the boundary.
REQ-028 SHALL allow a window to straddle the wrap point.

Reset
REQ-029 SHALL, on i_rst_n low, immediately and asynchronously set read pointer = 0, write pointer = 0, count = 0, o_consume_error = 0 and the stall counter = 0.
REQ-030 SHALL therefore present, during reset, o_window = all 8'h00, o_window_valid_bytes = 0 and o_fetch_ready = 1 (when i_flush is low).
REQ-031 SHALL NOT require buffer storage to be reset; invalid bytes are masked per REQ-017.
REQ-032 SHALL, when reset is asserted mid-operation, discard all queued bytes and any beat in flight.

Configuration
REQ-033 SHALL, when macro DECODE_STALL_COUNTER_EN is defined, add port o_stall_count, output, 16.
REQ-034 SHALL, with DECODE_STALL_COUNTER_EN defined, increment o_stall_count each cycle in which count == 0, i_flush is low and i_rst_n is high.
REQ-035 SHALL saturate o_stall_count at 16'hFFFF, clear it only by reset, and let it change one cycle after the starved cycle.
REQ-036 SHALL, without DECODE_STALL_COUNTER_EN, omit the port and all counter logic, with no other behaviour change.

Verification
REQ-037 SHALL cover fill: after reset, push beats 0x44332211 then 0x88776655 -> o_window = 11..88 and o_window_valid_bytes = 8 in the cycle after the second beat.
REQ-038 SHALL cover backpressure: fill to count 13 -> o_fetch_ready = 0; consume 1 -> count 12 and o_fetch_ready = 1 next cycle.
REQ-039 SHALL cover a simultaneous event: count 6, fetch beat plus consume 5 -> next-cycle count 5 and o_window[0] = old byte 5.
REQ-040 SHALL cover an illegal consume: count 3, consume 4 -> state unchanged and o_consume_error = 1 for one cycle only.
REQ-041 SHALL cover wrap and flush: advance rd_ptr to 14 with 8 valid bytes -> window spans buf[14], buf[15], buf[0..5]; then flush with a fetch offered -> count 0, beat not accepted, no error.
REQ-042 SHALL cover the stall counter (with DECODE_STALL_COUNTER_EN): 5 idle cycles after reset deassertion -> o_stall_count = 5; force a count of 16'hFFFF -> it holds at 16'hFFFF.
